seg_pipe_addsub: RTL and testbench
==================================

Name: seg_pipe_addsub

Overview:
- Parametrised, pipelined add/subtract unit for the execute stage and the multiply/divide datapath.
- Splits a WIDTH-bit operation into NSEG = WIDTH/SEG_W segments. One segment is resolved per pipeline stage, and the carry is registered between stages.
- Upper operand segments are skewed (carried forward in the pipeline) until their stage is reached.
- Sustains one operation per cycle, with valid/ready handshakes on both sides.
- Outputs carry-out, signed overflow and zero flags, plus a tag that passes through unchanged.

Parameters:
- WIDTH, 64: operand/result width.
- SEG_W, 16: segment width resolved per stage. WIDTH % SEG_W != 0 is an elaboration error ($error).
- TAG_W, 4: width of the pass-through tag.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  operation offered.
- IN_READY  out  1  operation accepted when IN_VALID && IN_READY.
- ADDER1  in  WIDTH  operand A.
- ADDER2  in  WIDTH  operand B.
- CARRY_I  in  1  carry/borrow in.
- IS_SUB  in  1  1 = subtract.
- TAG_I  in  TAG_W  user tag.
- OUT_VALID  out  1  result present.
- OUT_READY  in  1  consumer takes the result when OUT_VALID && OUT_READY.
- SUM  out  WIDTH  result.
- CARRY_O  out  1  carry out of bit WIDTH-1.
- OVF  out  1  two's-complement overflow.
- ZERO  out  1  SUM == 0.
- TAG_O  out  TAG_W  tag of the result.

Behaviour:
- Arithmetic:
  - B' = IS_SUB ? ~ADDER2 : ADDER2.
  - Initial carry c0 = IS_SUB ^ CARRY_I.
  - SUM = ADDER1 + B' + c0, modulo 2^WIDTH.
  - IS_SUB=1, CARRY_I=0 gives A-B. IS_SUB=1, CARRY_I=1 gives A-B-1.
  - CARRY_O is the raw carry out. For subtraction, 1 means no borrow.
  - OVF = (A[W-1] == B'[W-1]) && (SUM[W-1] != A[W-1]).
  - ZERO = ~|SUM.
- Pipeline:
  - NSEG stages. Stage k (0-based) adds segment k using the carry registered from stage k-1; stage 0 uses c0.
  - Each stage register holds:
    - valid bit
    - completed low result segments
    - pending upper A/B' segments
    - carry
    - per-segment zero bits
    - tag
  - The last stage holds the output registers. SUM/flags/TAG_O are driven directly from registers, with no combinational path from inputs.
- Latency: a transfer accepted on edge N gives OUT_VALID=1 after edge N+NSEG-1 when unstalled. With NSEG=1 the result appears after the accepting edge.
- Flow control:
  - adv = !OUT_VALID || OUT_READY. IN_READY = adv, so IN_READY depends combinationally on OUT_READY.
  - When adv=1, every stage shifts forward and stage 0 loads the input; a bubble is loaded if IN_VALID=0.
  - When adv=0, every stage holds, including the outputs.
  - The pipeline is global-stall and does not collapse bubbles.
  - Throughput is 1 op/cycle while OUT_READY=1.
- Simultaneous accept and output consume in the same cycle is legal and loses nothing.
- Data under OUT_VALID=1 with OUT_READY=0 must remain stable until taken.
- Reset (RESETN=0, any time including mid-operation):
  - All valid bits clear immediately.
  - In-flight operations are discarded.
  - SUM=0, CARRY_O=0, OVF=0, ZERO=0, TAG_O=0, OUT_VALID=0, IN_READY=1.
  - The first accept is legal on the first edge after deassertion.
- Operand values under IN_VALID=0 are don't-care and must not affect outputs.

Optional Feature:
- Macro: SEG_PIPE_ADDSUB_SAT_EN.
- When defined:
  - Adds input port SAT_I (1 bit, captured with the operation) and output port SAT_O.
  - If SAT_I=1 and OVF=1, SUM is clamped to the signed limit: 0x7FF..F if A[W-1]=0, else 0x800..0. SAT_O=1.
  - CARRY_O and OVF still report the unclamped result.
  - ZERO reflects the clamped SUM.
  - Clamping is applied in the final stage; latency is unchanged.
- When undefined: the ports are absent and SUM always wraps.

Test Plan (WIDTH=64, SEG_W=16, so latency 4):
- Wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=1, add, CARRY_I=0, TAG=5, accepted edge 0 → OUT_VALID at edge 3, SUM=0, CARRY_O=1, ZERO=1, OVF=0, TAG_O=5.
- Subtract: A=0x8000_0000_0000_0000, B=1, IS_SUB=1, CARRY_I=0 → SUM=0x7FFF_FFFF_FFFF_FFFF, OVF=1, CARRY_O=1. Same operands with CARRY_I=1 → SUM=0x7FFF_FFFF_FFFF_FFFE.
- Cross-segment carry: A=0x0000_FFFF_FFFF_FFFF, B=1 → SUM=0x0001_0000_0000_0000, CARRY_O=0.
- Streaming with stall:
  - 8 back-to-back ops (A=i, B=i<<16) with OUT_READY held low on cycles 5–7.
  - IN_READY must be 0 during the stall, outputs must hold, and all 8 results must arrive in order.
  - No duplicates or drops; results are compared against a reference model.
- Reset mid-flight: accept 3 ops, assert RESETN=0 for 1 cycle at cycle 2 → OUT_VALID never asserts for them, all outputs are 0, IN_READY=1 after release.
- SAT_EN: A=0x7FFF_FFFF_FFFF_FFFF, B=1, SAT_I=1 → SUM=0x7FFF_FFFF_FFFF_FFFF, SAT_O=1, OVF=1. With SAT_I=0 → SUM=0x8000_0000_0000_0000, SAT_O=0.

Source files
------------

// File: rtl/seg_pipe_addsub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : seg_pipe_addsub
// Purpose  : Segmented, pipelined add/subtract with valid/ready flow control.
//            Optional saturation is enabled by SEG_PIPE_ADDSUB_SAT_EN.
// Revision : 1.0
// ----------------------------------------------------------------------------
module seg_pipe_addsub #(
  parameter int WIDTH = 64,
  parameter int SEG_W = 16,
  parameter int TAG_W = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] ADDER1,
  input  logic [WIDTH-1:0] ADDER2,
  input  logic             CARRY_I,
  input  logic             IS_SUB,
  input  logic [TAG_W-1:0] TAG_I,
`ifdef SEG_PIPE_ADDSUB_SAT_EN
  input  logic             SAT_I,
  output logic             SAT_O,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY_O,
  output logic             OVF,
  output logic             ZERO,
  output logic [TAG_W-1:0] TAG_O
);

  localparam int NSEG = WIDTH / SEG_W;

  if ((WIDTH % SEG_W) != 0) begin : g_width_check
    $error("seg_pipe_addsub: WIDTH must be a multiple of SEG_W");
  end

  // Stage registers; index k holds the state after segment k is resolved.
  logic [NSEG-1:0]  r_valid;
  logic [NSEG-1:0]  r_carry;
  logic [WIDTH-1:0] r_sum  [NSEG];
  logic [WIDTH-1:0] r_a    [NSEG];
  logic [WIDTH-1:0] r_bp   [NSEG];
  logic [NSEG-1:0]  r_zseg [NSEG];
  logic [TAG_W-1:0] r_tag  [NSEG];
  logic             r_sat  [NSEG];
  logic             r_ovf;
  logic             r_zero;
`ifdef SEG_PIPE_ADDSUB_SAT_EN
  logic             r_sat_o;
`endif

  logic             w_adv;
  logic             w_sat_in;
  logic [NSEG-1:0]  w_v_src;
  logic [NSEG-1:0]  w_c_src;
  logic [WIDTH-1:0] w_a_src    [NSEG];
  logic [WIDTH-1:0] w_bp_src   [NSEG];
  logic [WIDTH-1:0] w_sum_src  [NSEG];
  logic [NSEG-1:0]  w_z_src    [NSEG];
  logic [TAG_W-1:0] w_tag_src  [NSEG];
  logic             w_sat_src  [NSEG];
  logic [SEG_W:0]   w_seg      [NSEG];
  logic [WIDTH-1:0] w_seg_ext  [NSEG];
  logic [WIDTH-1:0] w_sum_nx   [NSEG];
  logic [NSEG-1:0]  w_zseg_nx  [NSEG];
  logic             w_ovf;
  logic             w_clamp;
  logic             w_zero;
  logic [WIDTH-1:0] w_sum_out;

  assign w_adv = !r_valid[NSEG-1] || OUT_READY;

`ifdef SEG_PIPE_ADDSUB_SAT_EN
  assign w_sat_in = SAT_I;
`else
  assign w_sat_in = 1'b0;
`endif

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_v_src[k]   = IN_VALID;
      assign w_a_src[k]   = ADDER1;
      assign w_bp_src[k]  = IS_SUB ? ~ADDER2 : ADDER2;
      assign w_c_src[k]   = IS_SUB ^ CARRY_I;
      assign w_sum_src[k] = '0;
      assign w_z_src[k]   = '0;
      assign w_tag_src[k] = TAG_I;
      assign w_sat_src[k] = w_sat_in;
    end else begin : g_next
      assign w_v_src[k]   = r_valid[k-1];
      assign w_a_src[k]   = r_a[k-1];
      assign w_bp_src[k]  = r_bp[k-1];
      assign w_c_src[k]   = r_carry[k-1];
      assign w_sum_src[k] = r_sum[k-1];
      assign w_z_src[k]   = r_zseg[k-1];
      assign w_tag_src[k] = r_tag[k-1];
      assign w_sat_src[k] = r_sat[k-1];
    end

    assign w_seg[k] = {1'b0, w_a_src[k][k*SEG_W +: SEG_W]}
                    + {1'b0, w_bp_src[k][k*SEG_W +: SEG_W]}
                    + {{SEG_W{1'b0}}, w_c_src[k]};
    assign w_seg_ext[k] = WIDTH'(w_seg[k][SEG_W-1:0]);
    // Segments at and above k are still zero in the incoming partial sum.
    assign w_sum_nx[k]  = w_sum_src[k] | (w_seg_ext[k] << (k*SEG_W));
    assign w_zseg_nx[k] = w_z_src[k] | (NSEG'(w_seg[k][SEG_W-1:0] == '0) << k);
  end

  // Overflow and saturation are decided on the unclamped top segment.
  assign w_ovf   = (w_a_src[NSEG-1][WIDTH-1] == w_bp_src[NSEG-1][WIDTH-1])
                && (w_sum_nx[NSEG-1][WIDTH-1] != w_a_src[NSEG-1][WIDTH-1]);
  assign w_clamp = w_sat_src[NSEG-1] && w_ovf;
  assign w_sum_out = !w_clamp ? w_sum_nx[NSEG-1]
                   : (w_a_src[NSEG-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}});
  assign w_zero  = (&w_zseg_nx[NSEG-1]) && !w_clamp;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_valid <= '0;
      r_carry <= '0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
`ifdef SEG_PIPE_ADDSUB_SAT_EN
      r_sat_o <= 1'b0;
`endif
      for (int k = 0; k < NSEG; k++) begin
        r_sum[k]  <= '0;
        r_a[k]    <= '0;
        r_bp[k]   <= '0;
        r_zseg[k] <= '0;
        r_tag[k]  <= '0;
        r_sat[k]  <= 1'b0;
      end
    end else if (w_adv) begin
      r_valid <= w_v_src;
      // Bubbles leave the data registers untouched.
      for (int k = 0; k < NSEG; k++) begin
        if (w_v_src[k]) begin
          r_sum[k]   <= (k == NSEG-1) ? w_sum_out : w_sum_nx[k];
          r_a[k]     <= w_a_src[k];
          r_bp[k]    <= w_bp_src[k];
          r_carry[k] <= w_seg[k][SEG_W];
          r_zseg[k]  <= w_zseg_nx[k];
          r_tag[k]   <= w_tag_src[k];
          r_sat[k]   <= w_sat_src[k];
        end
      end
      if (w_v_src[NSEG-1]) begin
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
`ifdef SEG_PIPE_ADDSUB_SAT_EN
        r_sat_o <= w_clamp;
`endif
      end
    end
  end

  assign IN_READY  = w_adv;
  assign OUT_VALID = r_valid[NSEG-1];
  assign SUM       = r_sum[NSEG-1];
  assign CARRY_O   = r_carry[NSEG-1];
  assign OVF       = r_ovf;
  assign ZERO      = r_zero;
  assign TAG_O     = r_tag[NSEG-1];
`ifdef SEG_PIPE_ADDSUB_SAT_EN
  assign SAT_O     = r_sat_o;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_pipe_addsub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_seg_pipe_addsub
// Purpose  : Self-checking bench for seg_pipe_addsub (WIDTH=64, SEG_W=16).
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_seg_pipe_addsub;
  localparam int WIDTH = 64;
  localparam int SEG_W = 16;
  localparam int TAG_W = 4;
  localparam int LAT   = WIDTH / SEG_W - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             ci;
    logic [TAG_W-1:0] tag;
    logic             sat;
  } op_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] adder1 = '0;
  logic [WIDTH-1:0] adder2 = '0;
  logic             carry_i = 1'b0;
  logic             is_sub = 1'b0;
  logic [TAG_W-1:0] tag_i = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             carry_o;
  logic             ovf;
  logic             zero;
  logic [TAG_W-1:0] tag_o;
`ifdef SEG_PIPE_ADDSUB_SAT_EN
  logic             sat_i = 1'b0;
  logic             sat_o;
`endif

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  seg_pipe_addsub #(.WIDTH(WIDTH), .SEG_W(SEG_W), .TAG_W(TAG_W)) dut (
    .CLK      (clk),
    .RESETN   (rst_n),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .ADDER1   (adder1),
    .ADDER2   (adder2),
    .CARRY_I  (carry_i),
    .IS_SUB   (is_sub),
    .TAG_I    (tag_i),
`ifdef SEG_PIPE_ADDSUB_SAT_EN
    .SAT_I    (sat_i),
    .SAT_O    (sat_o),
`endif
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .SUM      (sum),
    .CARRY_O  (carry_o),
    .OVF      (ovf),
    .ZERO     (zero),
    .TAG_O    (tag_o)
  );

  always #5 clk = ~clk;

  // Whole-word reference: no segmentation involved.
  function automatic exp_t model(input op_t o);
    logic [WIDTH-1:0] bp;
    logic [WIDTH:0]   full;
    exp_t             e;
    bp    = o.sub ? ~o.b : o.b;
    full  = {1'b0, o.a} + {1'b0, bp} + (WIDTH+1)'(o.sub ^ o.ci);
    e.sum = full[WIDTH-1:0];
    e.co  = full[WIDTH];
    e.ovf = (o.a[WIDTH-1] == bp[WIDTH-1]) && (e.sum[WIDTH-1] != o.a[WIDTH-1]);
`ifdef SEG_PIPE_ADDSUB_SAT_EN
    if (o.sat && e.ovf)
      e.sum = o.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    e.zero = (e.sum == '0);
    e.tag  = o.tag;
    return e;
  endfunction

  function automatic exp_t observed();
    return {sum, carry_o, ovf, zero, tag_o};
  endfunction

  task automatic drive(input op_t o, input logic v);
    in_valid = v;
    adder1   = o.a;
    adder2   = o.b;
    is_sub   = o.sub;
    carry_i  = o.ci;
    tag_i    = o.tag;
`ifdef SEG_PIPE_ADDSUB_SAT_EN
    sat_i    = o.sat;
`endif
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_checks++;
    if (observed() !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got %h expected 0", observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  // Wrap-around add with exact latency measurement.
  task automatic test_latency();
    int   n;
    logic got;
    exp_t e;
    e = '{sum: 64'h0, co: 1'b1, ovf: 1'b0, zero: 1'b1, tag: 4'd5};
    @(negedge clk);
    out_ready = 1'b1;
    drive('{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'h1, sub: 1'b0, ci: 1'b0, tag: 4'd5, sat: 1'b0}, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      #1;
      if (out_valid) got = 1'b1;
    end
    n_checks++;
    if (n !== LAT) begin
      n_errors++; $display("FAIL wrap_latency: got %0d edges expected %0d", n, LAT);
    end
    n_checks++;
    if (observed() !== e) begin
      n_errors++; $display("FAIL wrap_result: got %h expected %h", observed(), e);
    end
  endtask

  task automatic test_directed();
    op_t  ops  [3];
    exp_t exps [3];
    exp_t e;
    int   idx = 0, got = 0, cyc = 0;
    ops[0]  = '{a: 64'h8000_0000_0000_0000, b: 64'h1, sub: 1'b1, ci: 1'b0, tag: 4'd1, sat: 1'b0};
    ops[1]  = '{a: 64'h8000_0000_0000_0000, b: 64'h1, sub: 1'b1, ci: 1'b1, tag: 4'd2, sat: 1'b0};
    ops[2]  = '{a: 64'h0000_FFFF_FFFF_FFFF, b: 64'h1, sub: 1'b0, ci: 1'b0, tag: 4'd3, sat: 1'b0};
    exps[0] = '{sum: 64'h7FFF_FFFF_FFFF_FFFF, co: 1'b1, ovf: 1'b1, zero: 1'b0, tag: 4'd1};
    exps[1] = '{sum: 64'h7FFF_FFFF_FFFF_FFFE, co: 1'b1, ovf: 1'b1, zero: 1'b0, tag: 4'd2};
    exps[2] = '{sum: 64'h0001_0000_0000_0000, co: 1'b0, ovf: 1'b0, zero: 1'b0, tag: 4'd3};
    while (got < 3 && cyc < 40) begin
      @(negedge clk);
      drive(ops[(idx < 3) ? idx : 2], idx < 3);
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++; $display("FAIL directed_extra: got %h expected none", observed());
        end else begin
          e = sb_q.pop_front();
          if (observed() !== e) begin
            n_errors++; $display("FAIL directed_result: got %h expected %h", observed(), e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(exps[idx]);
        idx++;
      end
      cyc++;
    end
    n_checks++;
    if (got !== 3) begin
      n_errors++; $display("FAIL directed_count: got %0d expected 3", got);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    op_t  ops [8];
    exp_t e;
    int   idx = 0, got = 0, cyc = 0;
    for (int i = 0; i < 8; i++)
      ops[i] = '{a: WIDTH'(i), b: WIDTH'(i) << 16, sub: 1'b0, ci: 1'b0, tag: TAG_W'(i), sat: 1'b0};
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      drive(ops[(idx < 8) ? idx : 7], idx < 8);
      out_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      if (cyc >= 5 && cyc <= 7) begin
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL stall_handshake: got valid=%b ready=%b expected valid=1 ready=0", out_valid, in_ready);
        end
        if (sb_q.size() != 0) begin
          n_checks++;
          if (observed() !== sb_q[0]) begin
            n_errors++; $display("FAIL stall_hold: got %h expected %h", observed(), sb_q[0]);
          end
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++; $display("FAIL stream_extra: got %h expected none", observed());
        end else begin
          e = sb_q.pop_front();
          if (observed() !== e) begin
            n_errors++; $display("FAIL stream_result: got %h expected %h", observed(), e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(ops[idx]));
        idx++;
      end
      cyc++;
    end
    n_checks++;
    if (got !== 8 || sb_q.size() != 0) begin
      n_errors++; $display("FAIL stream_count: got %0d results expected 8", got);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    int ghosts = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive('{a: WIDTH'(100 + i), b: WIDTH'(7), sub: 1'b0, ci: 1'b0, tag: TAG_W'(9 + i), sat: 1'b0}, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || observed() !== '0) begin
      n_errors++; $display("FAIL midreset_outputs: got valid=%b out=%h expected 0", out_valid, observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready);
    end
    repeat (8) begin
      @(negedge clk);
      #1;
      if (out_valid) ghosts++;
    end
    n_checks++;
    if (ghosts !== 0) begin
      n_errors++; $display("FAIL midreset_ghosts: got %0d valid cycles expected 0", ghosts);
    end
    n_checks++;
    if (observed() !== '0) begin
      n_errors++; $display("FAIL midreset_idle: got %h expected 0", observed());
    end
  endtask

`ifdef SEG_PIPE_ADDSUB_SAT_EN
  task automatic test_sat();
    op_t  o;
    exp_t e;
    logic got;
    int   n;
    for (int s = 1; s >= 0; s--) begin
      o = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'h1, sub: 1'b0, ci: 1'b0, tag: 4'd6, sat: s[0]};
      e = '{sum: (s == 1) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000,
            co: 1'b0, ovf: 1'b1, zero: 1'b0, tag: 4'd6};
      @(negedge clk);
      out_ready = 1'b1;
      drive(o, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        #1;
        if (out_valid) got = 1'b1;
      end
      n_checks++;
      if (!got || observed() !== e || sat_o !== s[0]) begin
        n_errors++;
        $display("FAIL sat_result: got %h sat=%b expected %h sat=%b", observed(), sat_o, e, s[0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
`ifdef SEG_PIPE_ADDSUB_SAT_EN
    test_sat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
